// File: rtl/bif_lbd_addr_seq_if.sv
// Local-bus address driver handshake bundle: requester/bus-side inputs
// and the sequencer's strobe, enable, mux-select and acknowledge outputs.
interface bif_lbd_addr_seq_if;
    logic CPU_REQ;
    logic DMA_REQ;
    logic LBUS_FREE;
    logic LWAIT;
    logic ECREQ;
    logic EADR_n;
    logic SEL_DMA;
    logic CPU_ACK;
    logic DMA_ACK;
    logic BUSY;
    logic ADR_TMO;

    modport master (
        input  CPU_REQ,
        input  DMA_REQ,
        input  LBUS_FREE,
        input  LWAIT,
        output ECREQ,
        output EADR_n,
        output SEL_DMA,
        output CPU_ACK,
        output DMA_ACK,
        output BUSY,
        output ADR_TMO
    );

    modport slave (
        output CPU_REQ,
        output DMA_REQ,
        output LBUS_FREE,
        output LWAIT,
        input  ECREQ,
        input  EADR_n,
        input  SEL_DMA,
        input  CPU_ACK,
        input  DMA_ACK,
        input  BUSY,
        input  ADR_TMO
    );
endinterface

// File: rtl/bif_lbd_addr_seq.sv
// BIF local-bus address phase sequencer with CPU/DMA round-robin arbitration.
// Optional DRIVE timeout enabled by defining BIF_LBD_TMO_EN.
module bif_lbd_addr_seq #(
    parameter int ADR_HOLD   = 2,
    parameter int GAP        = 1,
    parameter int TMO_CYCLES = 64
) (
    input  logic sysclk,
    input  logic sys_rst,
    bif_lbd_addr_seq_if.master bus
);

`ifdef BIF_LBD_TMO_EN
    localparam int CW = (TMO_CYCLES > 31) ? $clog2(TMO_CYCLES + 1) : 5;
    localparam logic [CW-1:0] TMO_M1 = CW'(TMO_CYCLES - 1);
`else
    localparam int CW = 5;
`endif
    localparam logic [CW-1:0] HOLD_M1 = CW'(ADR_HOLD - 1);
    localparam logic [CW-1:0] GAP_M1 = CW'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LATCH,
        S_DRIVE,
        S_TURN
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ecreq_q, ecreq_d;
    logic          eadr_n_q, eadr_n_d;
    logic          sel_dma_q, sel_dma_d;
    logic          cpu_ack_q, cpu_ack_d;
    logic          dma_ack_q, dma_ack_d;
    logic          busy_q, busy_d;
    logic          last_dma_q, last_dma_d;
`ifdef BIF_LBD_TMO_EN
    logic          tmo_q, tmo_d;
    logic          tmo_fire;
`endif

    logic [CW-1:0] cnt_inc;
    logic [CW-1:0] cnt_nx;
    logic          fin;
    logic          gnt_dma;

    // Outputs are registered, so the last DRIVE cycle is decided at the
    // edge that enters it, using the count that cycle will carry.
    always_comb begin
        cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CW'(1);
        cnt_nx  = (state_q == S_LATCH) ? '0 : cnt_inc;
        fin     = (cnt_nx >= HOLD_M1) && !bus.LWAIT;
`ifdef BIF_LBD_TMO_EN
        tmo_fire = 1'b0;
        if (!fin && cnt_nx == TMO_M1) begin
            fin      = 1'b1;
            tmo_fire = 1'b1;
        end
`endif
        gnt_dma = bus.DMA_REQ && (!bus.CPU_REQ || !last_dma_q);
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ecreq_d    = 1'b0;
        eadr_n_d   = 1'b1;
        sel_dma_d  = sel_dma_q;
        cpu_ack_d  = 1'b0;
        dma_ack_d  = 1'b0;
        busy_d     = 1'b1;
        last_dma_d = last_dma_q;
`ifdef BIF_LBD_TMO_EN
        tmo_d      = 1'b0;
`endif
        unique case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (bus.LBUS_FREE && (bus.CPU_REQ || bus.DMA_REQ)) begin
                    state_d    = S_LATCH;
                    ecreq_d    = 1'b1;
                    busy_d     = 1'b1;
                    sel_dma_d  = gnt_dma;
                    last_dma_d = gnt_dma;
                end
            end
            S_LATCH: begin
                state_d   = S_DRIVE;
                cnt_d     = cnt_nx;
                eadr_n_d  = 1'b0;
                cpu_ack_d = fin && !sel_dma_q;
                dma_ack_d = fin && sel_dma_q;
`ifdef BIF_LBD_TMO_EN
                tmo_d     = tmo_fire;
`endif
            end
            S_DRIVE: begin
                if (cpu_ack_q || dma_ack_q) begin
                    cnt_d = '0;
                    if (GAP > 0) begin
                        state_d = S_TURN;
                    end else begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                    end
                end else begin
                    cnt_d     = cnt_nx;
                    eadr_n_d  = 1'b0;
                    cpu_ack_d = fin && !sel_dma_q;
                    dma_ack_d = fin && sel_dma_q;
`ifdef BIF_LBD_TMO_EN
                    tmo_d     = tmo_fire;
`endif
                end
            end
            S_TURN: begin
                if (cnt_q >= GAP_M1) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (sys_rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            ecreq_q    <= 1'b0;
            eadr_n_q   <= 1'b1;
            sel_dma_q  <= 1'b0;
            cpu_ack_q  <= 1'b0;
            dma_ack_q  <= 1'b0;
            busy_q     <= 1'b0;
            last_dma_q <= 1'b1;
`ifdef BIF_LBD_TMO_EN
            tmo_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ecreq_q    <= ecreq_d;
            eadr_n_q   <= eadr_n_d;
            sel_dma_q  <= sel_dma_d;
            cpu_ack_q  <= cpu_ack_d;
            dma_ack_q  <= dma_ack_d;
            busy_q     <= busy_d;
            last_dma_q <= last_dma_d;
`ifdef BIF_LBD_TMO_EN
            tmo_q      <= tmo_d;
`endif
        end
    end

    assign bus.ECREQ   = ecreq_q;
    assign bus.EADR_n  = eadr_n_q;
    assign bus.SEL_DMA = sel_dma_q;
    assign bus.CPU_ACK = cpu_ack_q;
    assign bus.DMA_ACK = dma_ack_q;
    assign bus.BUSY    = busy_q;
`ifdef BIF_LBD_TMO_EN
    assign bus.ADR_TMO = tmo_q;
`else
    assign bus.ADR_TMO = 1'b0;
`endif

endmodule

// File: tb/tb_bif_lbd_addr_seq.sv
// Bench for bif_lbd_addr_seq: directed phases with literal expectations plus
// randomized traffic against a phase-timeline reference model.
module tb_bif_lbd_addr_seq;
    localparam int HOLD = 2;
    localparam int GAPC = 1;
    localparam int TMOC = 8;

    logic sysclk = 1'b0;
    logic sys_rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    bif_lbd_addr_seq_if bus ();

    bif_lbd_addr_seq #(
        .ADR_HOLD(HOLD),
        .GAP(GAPC),
        .TMO_CYCLES(TMOC)
    ) dut (
        .sysclk(sysclk),
        .sys_rst(sys_rst),
        .bus(bus.master)
    );

    always #5 sysclk = ~sysclk;

    // Reference: a phase is granted at the edge entering its LATCH cycle
    // (n=0); drive cycles are n=1..L, turnaround n=L+1..L+GAP.
    logic m_ok = 1'b0;
    logic m_act = 1'b0;
    logic m_last_dma = 1'b1;
    logic m_g = 1'b0;
    logic m_tmo = 1'b0;
    int   m_n = 0;
    int   m_L = 0;
    logic [6:0] m_exp = 7'b0100000;

    always @(posedge sysclk) begin
        if (sys_rst) begin
            m_act = 1'b0;
            m_last_dma = 1'b1;
            m_g = 1'b0;
            m_tmo = 1'b0;
            m_L = 0;
            m_n = 0;
        end else if (!m_act) begin
            if (bus.LBUS_FREE && (bus.CPU_REQ || bus.DMA_REQ)) begin
                m_g = bus.DMA_REQ && (!bus.CPU_REQ || !m_last_dma);
                m_last_dma = m_g;
                m_act = 1'b1;
                m_n = 0;
                m_L = 0;
                m_tmo = 1'b0;
            end
        end else begin
            m_n++;
            if (m_L != 0 && m_n == m_L + GAPC + 1) begin
                m_act = 1'b0;
            end else if (m_L == 0) begin
                if (m_n >= HOLD && !bus.LWAIT) begin
                    m_L = m_n;
                end
`ifdef BIF_LBD_TMO_EN
                else if (m_n == TMOC) begin
                    m_L = m_n;
                    m_tmo = 1'b1;
                end
`endif
            end
        end
        m_exp[6] = m_act && m_n == 0;
        m_exp[5] = !(m_act && m_n >= 1 && (m_L == 0 || m_n <= m_L));
        m_exp[4] = m_g;
        m_exp[3] = m_act && m_L != 0 && m_n == m_L && !m_g;
        m_exp[2] = m_act && m_L != 0 && m_n == m_L && m_g;
        m_exp[1] = m_act;
        m_exp[0] = m_act && m_L != 0 && m_n == m_L && m_tmo;
        m_ok = 1'b1;
    end

    logic [6:0] got;
    assign got = {bus.ECREQ, bus.EADR_n, bus.SEL_DMA, bus.CPU_ACK,
                  bus.DMA_ACK, bus.BUSY, bus.ADR_TMO};

    always @(negedge sysclk) begin
        if (m_ok) begin
            total++;
            if (got !== m_exp) begin
                bad++;
                $display("FAIL model_cmp t=%0t got=%b want=%b",
                         $time, got, m_exp);
            end
            total++;
            if ((bus.ECREQ && !bus.EADR_n) || (bus.CPU_ACK && bus.DMA_ACK)) begin
                bad++;
                $display("FAIL exclusivity t=%0t got=%b want=no overlap",
                         $time, got);
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge sysclk);
    endtask

    task automatic idle_inputs();
        bus.CPU_REQ = 1'b0;
        bus.DMA_REQ = 1'b0;
        bus.LBUS_FREE = 1'b0;
        bus.LWAIT = 1'b0;
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        idle_inputs();
        cyc(2);
        sys_rst = 1'b0;
        cyc(1);
    endtask

    task automatic wait_ecreq(input string nm, input int budget);
        int k;
        k = 0;
        while (!bus.ECREQ && k < budget) begin
            cyc(1);
            k++;
        end
        chk(nm, int'(bus.ECREQ), 1);
    endtask

    task automatic wait_ack(input string nm, input int budget);
        int k;
        k = 0;
        while (!(bus.CPU_ACK || bus.DMA_ACK) && k < budget) begin
            cyc(1);
            k++;
        end
        chk(nm, int'(bus.CPU_ACK || bus.DMA_ACK), 1);
    endtask

    initial begin
        logic sel_q[$];
        int   ca, da, lows, ecr, ackk, tmok;
        idle_inputs();
        cyc(2);
        chk("reset_outputs", int'(got), 7'b0100000);
        sys_rst = 1'b0;
        cyc(1);

        // single CPU phase, latency pinned by hand
        bus.LBUS_FREE = 1'b1;
        bus.CPU_REQ = 1'b1;
        cyc(1);
        chk("c1_latch", int'(got), 7'b1100010);
        cyc(1);
        chk("c2_drive", int'(got), 7'b0000010);
        cyc(1);
        chk("c3_ack", int'(got), 7'b0001010);
        bus.CPU_REQ = 1'b0;
        cyc(1);
        chk("c4_turn", int'(got), 7'b0100010);
        cyc(1);
        chk("c5_idle", int'(got), 7'b0100000);

        // both requesters held: round-robin from reset
        do_reset();
        bus.LBUS_FREE = 1'b1;
        bus.CPU_REQ = 1'b1;
        bus.DMA_REQ = 1'b1;
        ca = 0;
        da = 0;
        for (int i = 0; i < 60 && ca + da < 4; i++) begin
            cyc(1);
            if (bus.ECREQ) sel_q.push_back(bus.SEL_DMA);
            if (bus.CPU_ACK) ca++;
            if (bus.DMA_ACK) da++;
        end
        bus.CPU_REQ = 1'b0;
        bus.DMA_REQ = 1'b0;
        chk("rr_cpu_acks", ca, 2);
        chk("rr_dma_acks", da, 2);
        chk("rr_grants", sel_q.size(), 4);
        if (sel_q.size() == 4)
            chk("rr_order", int'({sel_q[0], sel_q[1], sel_q[2], sel_q[3]}), 4'b0101);
        cyc(4);

        // bus not free holds off the DMA request
        do_reset();
        bus.DMA_REQ = 1'b1;
        ecr = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            if (bus.ECREQ || bus.BUSY) ecr++;
        end
        chk("busfree_early", ecr, 0);
        bus.LBUS_FREE = 1'b1;
        cyc(1);
        chk("busfree_latch", int'({bus.ECREQ, bus.SEL_DMA}), 2'b11);
        wait_ack("busfree_ack", 20);
        bus.DMA_REQ = 1'b0;
        cyc(4);

        // LWAIT stretches the drive window
        do_reset();
        bus.LBUS_FREE = 1'b1;
        bus.CPU_REQ = 1'b1;
        wait_ecreq("lwait_latch", 10);
        bus.LWAIT = 1'b1;
        lows = 0;
        ecr = 1;
        ackk = 0;
        for (int k = 1; k <= 12; k++) begin
            cyc(1);
            if (!bus.EADR_n) lows++;
            if (bus.ECREQ) ecr++;
            if (bus.CPU_ACK) begin
                ackk = k;
                bus.CPU_REQ = 1'b0;
            end
            if (k == 5) bus.LWAIT = 1'b0;
        end
        chk("lwait_low_cycles", lows, 6);
        chk("lwait_ack_cycle", ackk, 6);
        chk("lwait_ecreq_pulses", ecr, 1);

        // reset in the middle of a drive window
        do_reset();
        bus.LBUS_FREE = 1'b1;
        bus.LWAIT = 1'b1;
        bus.CPU_REQ = 1'b1;
        wait_ecreq("rst_latch", 10);
        cyc(2);
        chk("rst_in_drive", int'(bus.EADR_n), 0);
        sys_rst = 1'b1;
        cyc(1);
        chk("rst_abort", int'({bus.EADR_n, bus.BUSY, bus.CPU_ACK, bus.ECREQ}), 4'b1000);
        sys_rst = 1'b0;
        bus.LWAIT = 1'b0;
        wait_ecreq("rst_fresh_latch", 10);
        wait_ack("rst_fresh_ack", 20);
        bus.CPU_REQ = 1'b0;
        cyc(4);

`ifdef BIF_LBD_TMO_EN
        do_reset();
        bus.LBUS_FREE = 1'b1;
        bus.LWAIT = 1'b1;
        bus.CPU_REQ = 1'b1;
        wait_ecreq("tmo_latch", 10);
        lows = 0;
        ackk = 0;
        tmok = 0;
        for (int k = 1; k <= 14; k++) begin
            cyc(1);
            if (!bus.EADR_n) lows++;
            if (bus.ADR_TMO) tmok = k;
            if (bus.CPU_ACK) begin
                ackk = k;
                bus.CPU_REQ = 1'b0;
            end
        end
        bus.LWAIT = 1'b0;
        chk("tmo_low_cycles", lows, 8);
        chk("tmo_ack_cycle", ackk, 8);
        chk("tmo_pulse_cycle", tmok, 8);
`else
        tmok = 0;
`endif

        // randomized traffic, checked every cycle by the model
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if (bus.CPU_ACK || $urandom_range(0, 39) == 0) bus.CPU_REQ = 1'b0;
            else if (!bus.CPU_REQ) bus.CPU_REQ = ($urandom_range(0, 2) == 0);
            if (bus.DMA_ACK || $urandom_range(0, 39) == 0) bus.DMA_REQ = 1'b0;
            else if (!bus.DMA_REQ) bus.DMA_REQ = ($urandom_range(0, 2) == 0);
            bus.LBUS_FREE = ($urandom_range(0, 3) != 0);
            bus.LWAIT = ($urandom_range(0, 2) == 0);
            sys_rst = ($urandom_range(0, 249) == 0);
            cyc(1);
        end
        sys_rst = 1'b0;
        idle_inputs();
        cyc(8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
